// File: rtl/rca_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_ctrl_if
// Description : Operand/result valid-ready bundle for rca_seq_ctrl.
//               Carries ovf only when RCA_SEQ_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rca_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef RCA_SEQ_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef RCA_SEQ_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef RCA_SEQ_OVF_EN
        , output ovf
`endif
    );
endinterface
`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_ctrl
// Description : Multi-cycle WIDTH-bit adder built from one 4-bit ripple slice,
//               LS nibble first. Optional macro RCA_SEQ_OVF_EN adds ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    rca_seq_ctrl_if.slave   bus
);
    localparam int C_NIB = WIDTH / 4;
    localparam int C_CW  = (C_NIB > 1) ? $clog2(C_NIB) : 1;
    localparam logic [C_CW-1:0] C_CNT_ONE  = C_CW'(1);
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(C_NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_width_check
            $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [C_CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef RCA_SEQ_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_slice;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    assign w_accept = (state_q == S_IDLE) && bus.in_valid;
    assign w_last   = (cnt_q == C_CNT_LAST);

    // Nibble selection as an explicit mux keeps every operand bit in use.
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int i = 0; i < C_NIB; i++) begin
            if (cnt_q == i[C_CW-1:0]) begin
                w_a_nib = a_q[4*i +: 4];
                w_b_nib = b_q[4*i +: 4];
            end
        end
    end

    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'd0, carry_q};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_RUN;
            S_RUN:   if (w_last)        state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (state_q)
            S_IDLE:  w_in_ready = 1'b1;
            S_RUN:   w_busy     = 1'b1;
            S_DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef RCA_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (w_accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            sum_d[{cnt_q, 2'b00} +: 4] = w_slice[3:0];
            carry_d                    = w_slice[4];
            if (w_last) begin
                cout_d = w_slice[4];
`ifdef RCA_SEQ_OVF_EN
                // Carry into the MSB is recovered as sum ^ a ^ b at bit 3.
                ovf_d  = (w_a_nib[3] ^ w_b_nib[3] ^ w_slice[3]) ^ w_slice[4];
`endif
            end else begin
                cnt_d = cnt_q + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef RCA_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef RCA_SEQ_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_seq_ctrl
// Description : Directed and random transactions for rca_seq_ctrl, checked
//               against arithmetic computed directly from the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_seq_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rca_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for result, optional backpressure, drain.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input int bp, input string tag);
        logic [WIDTH:0]   exp_full;
        logic [WIDTH-1:0] held_sum;
        logic             held_cout;
        int               lat;
        int               sres;
        logic             exp_ovf;

        exp_full = {1'b0, ta} + {1'b0, tb_} + {{WIDTH{1'b0}}, tc};
        sres     = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
        exp_ovf  = (sres > 32767) || (sres < -32768);

        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_;
        bus.cin       = tc;
        bus.out_ready = 1'($urandom);
        tick();
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
        bus.cin      = 1'($urandom);

        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            bus.out_ready = 1'($urandom);
            tick();
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(NIB));
        check({tag, ".sum"},     32'(bus.sum),  32'(exp_full[WIDTH-1:0]));
        check({tag, ".cout"},    32'(bus.cout), 32'(exp_full[WIDTH]));
`ifdef RCA_SEQ_OVF_EN
        check({tag, ".ovf"},     32'(bus.ovf),  32'(exp_ovf));
`else
        if (exp_ovf && !bus.out_valid) n_fail = n_fail; // keep exp_ovf referenced
`endif
        check({tag, ".busy"},    32'(bus.busy), 32'd1);

        held_sum  = bus.sum;
        held_cout = bus.cout;
        bus.out_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = WIDTH'($urandom);
            tick();
            check({tag, ".bp_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".bp_ready"}, 32'(bus.in_ready),  32'd0);
            check({tag, ".bp_sum"},   32'(bus.sum),       32'(held_sum));
            check({tag, ".bp_cout"},  32'(bus.cout),      32'(held_cout));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".drain_ready"}, 32'(bus.in_ready),  32'd1);
        check({tag, ".drain_busy"},  32'(bus.busy),      32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".sum"},       32'(bus.sum),       32'd0);
        check({tag, ".cout"},      32'(bus.cout),      32'd0);
        check({tag, ".busy"},      32'(bus.busy),      32'd0);
`ifdef RCA_SEQ_OVF_EN
        check({tag, ".ovf"},       32'(bus.ovf),       32'd0);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        int               seen_valid;

        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_values("reset0");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check_reset_values("post_reset");

        run_op(16'h1234, 16'h4321, 1'b0, 0,  "basic");
        run_op(16'hFFFF, 16'h0000, 1'b1, 0,  "ripple");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0,  "sovf_pos");
        run_op(16'h8000, 16'h8000, 1'b0, 0,  "sovf_neg");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 10, "backpressure");

        // Abort two cycles into RUN; reset takes effect before the next edge.
        bus.in_valid = 1'b1;
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        bus.cin      = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("abort.busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort_async");
        tick();
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen_valid++;
        end
        check("abort.no_valid", 32'(seen_valid), 32'd0);
        run_op(16'h0001, 16'h0001, 1'b0, 0, "after_abort");

        for (int k = 0; k < 24; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), "rand");
        end

        // A result waiting in DONE is also discarded by reset.
        bus.in_valid = 1'b1;
        bus.a        = 16'h0F0F;
        bus.b        = 16'h0101;
        bus.cin      = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        repeat (NIB) tick();
        check("done_abort.valid_before", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("done_abort");
        tick();
        rst_n = 1'b1;
        tick();
        check("done_abort.idle", 32'(bus.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Sequencing controller that adds two WIDTH-bit operands by driving one internal 4-bit ripple-carry add slice (a+b+cin) over WIDTH/4 consecutive cycles, least-significant nibble first. The carry is registered between slices. Sits between an upstream valid/ready producer and a downstream valid/ready consumer.
Trades latency for area versus a flat WIDTH-bit adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
cin  input  1  carry into nibble 0, sampled on accept
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result sum, registered
cout  output  1  carry out of top nibble, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, busy=0, nibble counter=0, carry reg=0, operand regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. An accept (in_valid & in_ready) latches a, b and cin into internal registers, clears the counter and moves to RUN. Without an accept the FSM holds.
- RUN: in_ready=0. Each cycle the slice adds nibble[cnt] of A, nibble[cnt] of B and the carry reg.
  - Slice sum is written into sum[4*cnt+3:4*cnt].
  - Slice carry is written into the carry reg.
  - cnt increments by 1.
  - When cnt==WIDTH/4-1, slice carry goes to cout and the FSM moves to DONE.
  - The counter is ceil(log2(WIDTH/4)) bits wide, minimum 1. It never wraps; it is cleared on accept.
- DONE: out_valid=1; sum and cout are stable and held.
  - out_ready=1 clears out_valid and returns to IDLE.
  - out_ready=0 holds DONE indefinitely (backpressure).
- Latency: accept on edge N gives out_valid=1 after edge N+WIDTH/4. No pipelining; one transaction in flight.
- Throughput: one result per WIDTH/4+2 cycles when out_ready is tied high.
- in_ready is combinationally equal to (state==IDLE). It never depends on in_valid or out_ready.
- sum bits not yet written during RUN keep their previous values. Consumers use sum/cout only while out_valid=1.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned.
- Operand changes on a/b/cin after accept have no effect.
- out_ready asserted outside DONE is ignored.
- rst_n low mid-RUN or in DONE aborts immediately to reset values. The in-flight result is discarded, and no out_valid pulse follows.

Optional Feature:
Macro RCA_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit), registered alongside cout. ovf = signed two's-complement overflow, i.e. carry-into-MSB XOR carry-out-of-MSB, captured on the final RUN cycle. It resets to 0, is held in DONE and is valid only with out_valid.
- Undefined: port ovf absent, with no extra logic; all other behaviour identical.

Test Plan:
- Reset: rst_n=0 at any state -> in_ready=1, out_valid=0, sum=0, cout=0, busy=0 asynchronously, before the next clk edge.
- Basic add, WIDTH=16: a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_valid on the 4th edge after accept; sum=0x5555, cout=0; in_ready high again the following cycle.
- Full carry ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. With RCA_SEQ_OVF_EN: ovf=0.
- Signed overflow (RCA_SEQ_OVF_EN): a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Case a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> sum/cout stable, in_ready=0, a new in_valid is not accepted. out_ready=1 -> return to IDLE next edge.
- Reset mid-op: assert rst_n=0 two cycles into RUN of a=0xAAAA, b=0x5555, release -> no out_valid. The next request a=0x0001, b=0x0001, cin=0 yields sum=0x0002, cout=0.
